gate_bank_seq: RTL

//  Next-generation gate/latch selector: a WIDTH-bit bank that applies one selectable

---
 rtl/gate_sel_pkg.sv | 23 ++
 rtl/gate_bank_seq_rise_detect.sv | 20 ++
 rtl/gate_bank_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/gate_sel_pkg.sv
// Shared select encodings and classification helpers for the gate/latch bank.
package gate_sel_pkg;

    localparam logic [3:0] SEL_AND  = 4'd0;
    localparam logic [3:0] SEL_OR   = 4'd1;
    localparam logic [3:0] SEL_NAND = 4'd2;
    localparam logic [3:0] SEL_NOR  = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_XNOR = 4'd5;
    localparam logic [3:0] SEL_SR   = 4'd6;
    localparam logic [3:0] SEL_T    = 4'd7;
    localparam logic [3:0] SEL_D    = 4'd8;
    localparam logic [3:0] SEL_JK   = 4'd9;

    function automatic logic is_storage(input logic [3:0] sel);
        return (sel >= SEL_SR) && (sel <= SEL_JK);
    endfunction

    function automatic logic is_valid(input logic [3:0] sel);
        return sel <= SEL_JK;
    endfunction

endpackage

// File: rtl/gate_bank_seq_rise_detect.sv
// Rising-edge detector for the update strobe: registered history, combinational pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    output logic stb_d,
    output logic stb_rise
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_d <= 1'b0;
        end else begin
            stb_d <= stb;
        end
    end

    assign stb_rise = stb & ~stb_d;

endmodule

// File: rtl/gate_bank_seq.sv
// WIDTH-bit gate/latch bank: selectable bitwise gate or strobed storage element,
// registered result with validity flag and a count of accepted storage updates.
module gate_bank_seq
    import gate_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             stb,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] gate_y;
    logic [3:0]       sel_d;
    logic             sel_chg;
    logic             stb_d;
    logic             stb_rise;

    rise_detect u_rise_detect (
        .clk      (clk),
        .reset    (reset),
        .stb      (stb),
        .stb_d    (stb_d),
        .stb_rise (stb_rise)
    );

    assign sel_chg = (sel != sel_d);

    always_comb begin
        gate_y = '0;
        qn     = q;
        case (sel)
            SEL_AND:  gate_y = a & b;
            SEL_OR:   gate_y = a | b;
            SEL_NAND: gate_y = ~(a & b);
            SEL_NOR:  gate_y = ~(a | b);
            SEL_XOR:  gate_y = a ^ b;
            SEL_XNOR: gate_y = ~(a ^ b);
            SEL_SR:   qn = (q | a) & ~b;   // R dominates when S=R=1
            SEL_T:    qn = q ^ a;
            SEL_D:    qn = a;
            SEL_JK:   qn = (a & ~q) | (~b & q);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            evt_cnt <= '0;
            q       <= '0;
            sel_d   <= SEL_AND;
        end else begin
            sel_d <= sel;
            if (sel_chg) begin
                // a strobe edge landing on a select change is deliberately dropped
                q       <= '0;
                y       <= '0;
                y_valid <= 1'b0;
                evt_cnt <= '0;
            end else if (!is_valid(sel)) begin
                y       <= '0;
                y_valid <= 1'b0;
            end else if (!is_storage(sel)) begin
                y       <= gate_y;
                y_valid <= 1'b1;
            end else if (stb_rise) begin
                q       <= qn;
                y       <= qn;
                y_valid <= 1'b1;
                evt_cnt <= evt_cnt + CNT_ONE;
            end else begin
                y       <= q;
                y_valid <= 1'b1;
            end
        end
    end

endmodule
